// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset core: opcodes, functs,
// FSM states and the internal ALU operation codes.
package cpu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} cpu_state_e;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  // Anything not listed here, including opcode 6'h3F, stops the core.
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE:                          return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_cpu_if.sv
// Instruction and data memory req/ready buses; master = core, slave = memories.
interface multicycle_cpu_if #(
  parameter int XLEN = cpu_pkg::XLEN_DEFAULT
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ready;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/regfile.sv
// Register file: two combinational reads, one synchronous write, r0 fixed at 0.
// Indices at or above NREG have no storage: they read 0 and ignore writes.
module regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [32];

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      if (gi > 0 && gi < NREG) begin : g_impl
        logic [XLEN-1:0] q_reg;
        always_ff @(posedge clk) begin
          if (!rst_n)
            q_reg <= '0;
          else if (we && waddr == 5'(gi))
            q_reg <= wdata;
        end
        assign regs[gi] = q_reg;
      end else begin : g_zero
        assign regs[gi] = '0;
      end
    end
  endgenerate

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB/HALT over one shared
// ALU, with handshaked instruction and data memories.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  multicycle_cpu_if.master  bus,
  output logic [XLEN-1:0]   Result,
  output logic [XLEN-1:0]   Addr,
  output logic              retire,
  output logic              halted
);

  cpu_state_e      state_reg;
  logic [XLEN-1:0] pc_reg, ir_pc_reg, a_reg, b_reg, alu_reg, mdr_reg, result_reg;
  logic [31:0]     ir_reg;
  logic            halted_reg;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;

  assign op     = ir_reg[31:26];
  assign rs     = ir_reg[25:21];
  assign rt     = ir_reg[20:16];
  assign rd     = ir_reg[15:11];
  assign imm    = ir_reg[15:0];
  assign funct  = ir_reg[5:0];
  assign target = ir_reg[25:0];

  logic [XLEN-1:0] sext_imm, alu_b, alu_res;
  alu_op_e         alu_op;

  assign sext_imm = {{(XLEN-16){imm[15]}}, imm};
  assign alu_b    = (op == OP_RTYPE) ? b_reg : sext_imm;

  always_comb begin
    alu_op = ALU_ADD;
    if (op == OP_RTYPE) begin
      case (funct)
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_SLT:  alu_op = ALU_SLT;
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  always_comb begin
    case (alu_op)
      ALU_ADD: alu_res = a_reg + alu_b;
      ALU_SUB: alu_res = a_reg - alu_b;
      ALU_AND: alu_res = a_reg & alu_b;
      ALU_OR:  alu_res = a_reg | alu_b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, $signed(a_reg) < $signed(alu_b)};
      default: alu_res = '0;
    endcase
  end

  logic [XLEN-1:0] rdata1, rdata2, wb_data;
  logic [4:0]      wb_addr;
  logic            rf_we;

  assign rf_we   = (state_reg == S_WB);
  assign wb_addr = (op == OP_RTYPE) ? rd : rt;
  assign wb_data = (op == OP_LW) ? mdr_reg : alu_reg;

  regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk    (Clock),
    .rst_n  (Reset),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (rf_we),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_reg  <= S_FETCH;
      pc_reg     <= RESET_PC;
      ir_pc_reg  <= RESET_PC;
      ir_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      alu_reg    <= '0;
      mdr_reg    <= '0;
      result_reg <= '0;
      halted_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_FETCH: if (bus.imem_ready) begin
          ir_reg    <= bus.imem_rdata;
          ir_pc_reg <= pc_reg;
          pc_reg    <= pc_reg + XLEN'(4);
          state_reg <= S_DECODE;
        end
        S_DECODE: begin
          a_reg <= rdata1;
          b_reg <= rdata2;
          if (is_legal(op, funct)) begin
            state_reg <= S_EXEC;
          end else begin
            state_reg  <= S_HALT;
            halted_reg <= 1'b1;
          end
        end
        S_EXEC: begin
          alu_reg <= alu_res;
          // pc_reg already points at the following instruction here.
          case (op)
            OP_BEQ: begin
              if (a_reg == b_reg)
                pc_reg <= pc_reg + {sext_imm[XLEN-3:0], 2'b00};
              state_reg <= S_FETCH;
            end
            OP_J: begin
              pc_reg    <= {pc_reg[XLEN-1:28], target, 2'b00};
              state_reg <= S_FETCH;
            end
            OP_LW, OP_SW: state_reg <= S_MEM;
            default:      state_reg <= S_WB;
          endcase
        end
        S_MEM: if (bus.dmem_ready) begin
          if (op == OP_LW) begin
            mdr_reg   <= bus.dmem_rdata;
            state_reg <= S_WB;
          end else begin
            state_reg <= S_FETCH;
          end
        end
        S_WB: begin
          result_reg <= wb_data;
          state_reg  <= S_FETCH;
        end
        default: state_reg <= S_HALT;
      endcase
    end
  end

  // Requests come from registered state only; Reset gates them while low.
  assign bus.imem_req   = Reset && (state_reg == S_FETCH);
  assign bus.imem_addr  = pc_reg;
  assign bus.dmem_req   = Reset && (state_reg == S_MEM);
  assign bus.dmem_we    = (state_reg == S_MEM) && (op == OP_SW);
  assign bus.dmem_addr  = alu_reg;
  assign bus.dmem_wdata = b_reg;

  assign retire = (state_reg == S_WB)
               || (state_reg == S_EXEC && (op == OP_BEQ || op == OP_J))
               || (state_reg == S_MEM && bus.dmem_ready && op == OP_SW);

  assign halted = halted_reg;
  assign Result = result_reg;
  assign Addr   = (state_reg == S_FETCH) ? pc_reg : ir_pc_reg;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Self-checking bench for multicycle_cpu: wait-state memory models, a retire
// scoreboard (PC, Result, cycle gap) and a second 64-bit, 8-register instance.
module tb_multicycle_cpu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] HALT_INSN = 32'hFC00_0000;

  // 32-bit core, RESET_PC = 0x100
  logic        rst_n = 1'b0;
  logic [31:0] result, addr;
  logic        retire, halted;

  multicycle_cpu_if #(.XLEN(32)) bus();

  multicycle_cpu #(.XLEN(32), .NREG(32), .RESET_PC(32'h100)) dut (
    .Clock(clk), .Reset(rst_n), .bus(bus),
    .Result(result), .Addr(addr), .retire(retire), .halted(halted)
  );

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  int imem_wait = 0, dmem_wait = 0, icnt = 0, dcnt = 0;

  assign bus.imem_ready = bus.imem_req && (icnt >= imem_wait);
  assign bus.imem_rdata = imem[bus.imem_addr[9:2]];
  assign bus.dmem_ready = bus.dmem_req && (dcnt >= dmem_wait);
  assign bus.dmem_rdata = dmem[bus.dmem_addr[9:2]];

  always @(posedge clk) begin
    icnt <= (bus.imem_req && !bus.imem_ready) ? icnt + 1 : 0;
    dcnt <= (bus.dmem_req && !bus.dmem_ready) ? dcnt + 1 : 0;
    if (bus.dmem_req && bus.dmem_ready && bus.dmem_we)
      dmem[bus.dmem_addr[9:2]] <= bus.dmem_wdata;
  end

  // 64-bit core, NREG = 8, RESET_PC = 0, zero-wait instruction memory
  logic        rst64_n = 1'b0;
  logic [63:0] result64, addr64;
  logic        retire64, halted64;
  logic [31:0] imem64 [16];

  multicycle_cpu_if #(.XLEN(64)) bus64();

  multicycle_cpu #(.XLEN(64), .NREG(8), .RESET_PC(64'h0)) dut64 (
    .Clock(clk), .Reset(rst64_n), .bus(bus64),
    .Result(result64), .Addr(addr64), .retire(retire64), .halted(halted64)
  );

  assign bus64.imem_ready = bus64.imem_req;
  assign bus64.imem_rdata = imem64[bus64.imem_addr[5:2]];
  assign bus64.dmem_ready = bus64.dmem_req;
  assign bus64.dmem_rdata = '0;

  // Scoreboard: expected retires pushed with the program, observed ones
  // captured by the monitor (Result is sampled one cycle after the retire).
  typedef struct { logic [31:0] pc; logic [31:0] res; int gap; } exp_t;
  typedef struct { logic [31:0] pc; logic [31:0] res; int cyc; } obs_t;
  exp_t exp_q [$];
  obs_t obs_q [$];
  logic [63:0] st_q [$];

  int          cyc = 0;
  bit          pend = 0;
  logic [31:0] pend_pc;
  int          pend_cyc;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      pend = 0;
    end else begin
      if (pend) obs_q.push_back(obs_t'{pend_pc, result, pend_cyc});
      pend     = retire;
      pend_pc  = addr;
      pend_cyc = cyc;
      if (bus.dmem_req && bus.dmem_we) st_q.push_back({bus.dmem_addr, bus.dmem_wdata});
    end
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = HALT_INSN;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    obs_q.delete();
    st_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    while (obs_q.size() < n && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    clear_imem();
    rst_n = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_req imem_req=%b dmem_req=%b expected 0/0", bus.imem_req, bus.dmem_req);
    end
    checks++;
    if (result !== 32'h0 || retire !== 1'b0 || halted !== 1'b0 || addr !== 32'h100) begin
      failures++;
      $display("FAIL reset_values result=%h retire=%b halted=%b addr=%h expected 0/0/0/100",
               result, retire, halted, addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
      failures++;
      $display("FAIL reset_first_fetch imem_req=%b imem_addr=%h expected 1/00000100",
               bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_alu();
    exp_t e; obs_t o; bit ok; int prev;
    clear_imem();
    imem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[65] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    imem[66] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    imem[67] = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);
    exp_q.push_back(exp_t'{32'h100, 32'd5, 0});
    exp_q.push_back(exp_t'{32'h104, 32'hFFFF_FFFD, 4});
    exp_q.push_back(exp_t'{32'h108, 32'd2, 4});
    exp_q.push_back(exp_t'{32'h10C, 32'd1, 4});
    do_reset();
    wait_obs(4, 100, ok);
    repeat (6) @(negedge clk); #1;
    checks++;
    if (!ok) begin failures++; $display("FAIL alu_timeout retires=%0d expected 4", obs_q.size()); end
    prev = -1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) continue;
      o = obs_q.pop_front();
      checks++;
      if (o.pc !== e.pc || o.res !== e.res) begin
        failures++;
        $display("FAIL alu_retire pc=%h result=%h expected pc=%h result=%h", o.pc, o.res, e.pc, e.res);
      end
      if (e.gap != 0) begin
        checks++;
        if (o.cyc - prev != e.gap) begin
          failures++;
          $display("FAIL alu_cpi pc=%h gap=%0d expected %0d", o.pc, o.cyc - prev, e.gap);
        end
      end
      prev = o.cyc;
    end
    checks++;
    if (halted !== 1'b1 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL alu_halt halted=%b extra_retires=%0d expected 1/0", halted, obs_q.size());
    end
  endtask

  task automatic test_mem();
    exp_t e; obs_t o; bit ok; int prev;
    clear_imem();
    dmem[2]  = 32'hDEAD_BEEF;
    dmem_wait = 3;
    imem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[65] = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
    imem[66] = enc_i(6'h23, 5'd0, 5'd5, 16'd8);
    imem[67] = enc_r(5'd5, 5'd0, 5'd6, 6'h20);
    exp_q.push_back(exp_t'{32'h100, 32'd5, 0});
    exp_q.push_back(exp_t'{32'h104, 32'd5, 7});
    exp_q.push_back(exp_t'{32'h108, 32'd5, 8});
    exp_q.push_back(exp_t'{32'h10C, 32'd5, 4});
    do_reset();
    wait_obs(4, 150, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL mem_timeout retires=%0d expected 4", obs_q.size()); end
    prev = -1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) continue;
      o = obs_q.pop_front();
      checks++;
      if (o.pc !== e.pc || o.res !== e.res) begin
        failures++;
        $display("FAIL mem_retire pc=%h result=%h expected pc=%h result=%h", o.pc, o.res, e.pc, e.res);
      end
      if (e.gap != 0) begin
        checks++;
        if (o.cyc - prev != e.gap) begin
          failures++;
          $display("FAIL mem_cpi pc=%h gap=%0d expected %0d", o.pc, o.cyc - prev, e.gap);
        end
      end
      prev = o.cyc;
    end
    checks++;
    if (st_q.size() != 4) begin
      failures++;
      $display("FAIL mem_store_hold cycles=%0d expected 4", st_q.size());
    end
    foreach (st_q[i]) begin
      checks++;
      if (st_q[i] !== {32'd8, 32'd5}) begin
        failures++;
        $display("FAIL mem_store_bus cycle=%0d addr/data=%h expected 0000000800000005", i, st_q[i]);
      end
    end
    checks++;
    if (dmem[2] !== 32'd5) begin failures++; $display("FAIL mem_store_data mem=%h expected 5", dmem[2]); end
    dmem_wait = 0;
  endtask

  task automatic test_branch_jump();
    exp_t e; obs_t o; bit ok; int prev;
    for (int pass = 0; pass < 2; pass++) begin
      clear_imem();
      if (pass == 0) begin
        imem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
        imem[65] = enc_i(6'h04, 5'd0, 5'd1, 16'd5);
        imem[66] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
        exp_q.push_back(exp_t'{32'h100, 32'd1, 0});
        exp_q.push_back(exp_t'{32'h104, 32'd1, 3});
        exp_q.push_back(exp_t'{32'h108, 32'd1, 3});
        exp_q.push_back(exp_t'{32'h108, 32'd1, 3});
        exp_q.push_back(exp_t'{32'h108, 32'd1, 3});
      end else begin
        imem[64] = {6'h02, 26'h40};
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_t'{32'h100, 32'd0, (i == 0) ? 0 : 3});
      end
      do_reset();
      wait_obs(exp_q.size(), 100, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL branch_timeout pass=%0d retires=%0d", pass, obs_q.size()); end
      prev = -1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (obs_q.size() == 0) continue;
        o = obs_q.pop_front();
        checks++;
        if (o.pc !== e.pc || o.res !== e.res) begin
          failures++;
          $display("FAIL branch_retire pass=%0d pc=%h result=%h expected pc=%h result=%h",
                   pass, o.pc, o.res, e.pc, e.res);
        end
        if (e.gap != 0) begin
          checks++;
          if (o.cyc - prev != e.gap) begin
            failures++;
            $display("FAIL branch_period pass=%0d gap=%0d expected %0d", pass, o.cyc - prev, e.gap);
          end
        end
        prev = o.cyc;
      end
    end
  endtask

  task automatic test_halt();
    exp_t e; obs_t o; bit ok; int prev, retire_cyc, budget, busy;
    clear_imem();
    imem_wait = 2;
    imem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    imem[65] = enc_i(6'h08, 5'd0, 5'd2, 16'd2);
    exp_q.push_back(exp_t'{32'h100, 32'd1, 0});
    exp_q.push_back(exp_t'{32'h104, 32'd2, 6});
    do_reset();
    wait_obs(2, 100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL halt_timeout retires=%0d expected 2", obs_q.size()); end
    retire_cyc = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1].cyc : 0;
    budget = 20;
    while (halted !== 1'b1 && budget > 0) begin @(negedge clk); #1; budget--; end
    checks++;
    if (halted !== 1'b1 || cyc - retire_cyc != 5) begin
      failures++;
      $display("FAIL halt_timing halted=%b delay=%0d expected 1/5", halted, cyc - retire_cyc);
    end
    prev = -1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) continue;
      o = obs_q.pop_front();
      checks++;
      if (o.pc !== e.pc || o.res !== e.res) begin
        failures++;
        $display("FAIL halt_retire pc=%h result=%h expected pc=%h result=%h", o.pc, o.res, e.pc, e.res);
      end
      if (e.gap != 0) begin
        checks++;
        if (o.cyc - prev != e.gap) begin
          failures++;
          $display("FAIL halt_cpi gap=%0d expected %0d", o.cyc - prev, e.gap);
        end
      end
      prev = o.cyc;
    end
    busy = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (bus.imem_req || bus.dmem_req || retire) busy++;
    end
    checks++;
    if (busy != 0 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL halt_quiet active_cycles=%0d retires=%0d expected 0/0", busy, obs_q.size());
    end
    do_reset();
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_restart imem_req=%b imem_addr=%h halted=%b expected 1/00000100/0",
               bus.imem_req, bus.imem_addr, halted);
    end
    imem_wait = 0;
  endtask

  task automatic test_xlen64();
    logic [63:0] exp64_q [$];
    logic [63:0] e64;
    int n, budget;
    for (int i = 0; i < 16; i++) imem64[i] = HALT_INSN;
    imem64[0] = enc_i(6'h08, 5'd0, 5'd9, 16'd7);
    imem64[1] = enc_r(5'd1, 5'd0, 5'd2, 6'h20);
    imem64[2] = enc_r(5'd9, 5'd0, 5'd1, 6'h20);
    imem64[3] = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF);
    exp64_q.push_back(64'h0);
    exp64_q.push_back(64'h0);
    exp64_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    rst64_n = 1'b0;
    repeat (2) @(negedge clk);
    rst64_n = 1'b1;
    n = 0;
    budget = 200;
    while (n < 4 && budget > 0) begin
      @(negedge clk); #1;
      budget--;
      if (retire64) begin
        @(negedge clk); #1;
        if (n > 0) begin
          e64 = exp64_q.pop_front();
          checks++;
          if (result64 !== e64) begin
            failures++;
            $display("FAIL x64_result insn=%0d result=%h expected %h", n, result64, e64);
          end
        end
        n++;
      end
    end
    repeat (4) @(negedge clk); #1;
    checks++;
    if (n != 4 || halted64 !== 1'b1) begin
      failures++;
      $display("FAIL x64_complete retires=%0d halted=%b expected 4/1", n, halted64);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    test_reset();
    test_alu();
    test_mem();
    test_branch_jump();
    test_halt();
    test_xlen64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
